nes_controller_reader: RTL and testbench
========================================

Name: nes_controller_reader

Overview:
- Self-contained serial reader for one NES controller. It generates the latch and clock waveforms and shifts in the 8 button bits.
- It presents a debounced-by-poll, active-high button byte plus a one-cycle "newly pressed" mask.
- It sits directly upstream of the pong datapath: one instance per player.
- The paddle and start/select logic consumes pressed[] instead of decoding raw serial bits itself.

Parameters:
- PULSE_CYCLES, 152, clk cycles per latch-high / clock-low / clock-high phase (6 us at 25.175 MHz).
- POLL_CYCLES, 419583, clk cycles between frame starts (~60 Hz). Must exceed 16*PULSE_CYCLES+1.

Ports:
- clk  in  1  system clock (25.175 MHz)
- reset  in  1  synchronous, active-high reset
- enable  in  1  permits new frames to start; a frame in progress always completes
- nes_data  in  1  controller serial data, active-low (0 = pressed), asynchronous
- nes_latch  out  1  controller latch strobe, active-high
- nes_clk  out  1  controller shift clock
- buttons  out  8  current button state, active-high; bit7 A, 6 B, 5 Select, 4 Start, 3 Up, 2 Down, 1 Left, 0 Right
- pressed  out  8  bits that went 0->1 in the frame just completed; valid only while buttons_valid=1, else 0
- buttons_valid  out  1  one-cycle strobe when buttons/pressed update
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (clk edge with reset=1): all outputs 0, state IDLE, poll counter 0, phase counter 0, bit index 0, shift register 0, previous-buttons register 0. Reset mid-frame aborts the frame immediately: nes_latch=0 and nes_clk=0 on the next cycle.
- nes_data passes through a 2-flop synchronizer before use. The synchronized value is inverted to form the active-high bit.
- Poll counter:
  - Free-runs 0..POLL_CYCLES-1 and wraps, independent of state.
  - A frame starts when the counter equals POLL_CYCLES-1, the state is IDLE, and enable=1.
  - If enable=0 at that tick, no frame starts and there is no catch-up.
- States:
  - IDLE: latch=0, clk=0. On the trigger go to LATCH; phase counter=0.
  - LATCH: latch=1 for exactly PULSE_CYCLES cycles, then go to LOW with bit index=0.
  - LOW: clk=0 for PULSE_CYCLES cycles. On the last cycle, capture the inverted synchronized data into shift[7-idx]. If idx==7 go to DONE, else go to HIGH.
  - HIGH: clk=1 for PULSE_CYCLES cycles, then idx++ and go to LOW.
  - DONE: single cycle. buttons<=shift; pressed<=shift & ~prev; prev<=shift; buttons_valid=1 registered, so it is high the cycle after DONE alongside the new buttons. Then go to IDLE.
- Frame length from trigger to buttons_valid: 16*PULSE_CYCLES+2 cycles.
- Phase counter width: clog2(PULSE_CYCLES). Poll counter width: clog2(POLL_CYCLES). Both are compared against PARAM-1; there is no overflow path.
- buttons holds between frames. pressed and buttons_valid are 0 except on the strobe cycle.
- Disconnected controller (data pulled high): reads as all released, buttons=0x00.
- Simultaneous trigger and reset: reset wins.
- enable dropped mid-frame: the frame finishes and the strobe still fires.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package pong_pkg:
  - button bit-index constants (BTN_A=7 ... BTN_RIGHT=0);
  - state enum {IDLE, LATCH, LOW, HIGH, DONE};
  - default PULSE/POLL constants, shared with other timing users.
- One natural sub-module: sync_2ff, a generic 1-bit two-flop synchronizer with reset, reusable for the second controller and any other async input.

Test Plan (bench overrides PULSE_CYCLES=4, POLL_CYCLES=100 unless stated):
1. Reset, enable=1, model drives 8-bit pattern 0x5A (active-high, i.e. nes_data inverted) per latch/clk -> first strobe at cycle 99+66 after reset release; buttons=0x5A, pressed=0x5A; latch high exactly 4 cycles; 7 clk-high pulses of 4 cycles each.
2. Second frame with pattern 0x5B -> buttons=0x5B, pressed=0x01 (Right only); third frame 0x5B -> pressed=0x00, buttons_valid still pulses.
3. nes_data held high (no controller) -> buttons=0x00 every frame, pressed=0x00.
4. Assert reset during HIGH of bit 3 -> next cycle nes_latch=0, nes_clk=0, busy=0, buttons=0x00; no strobe; the next frame starts 100 cycles after reset release.
5. enable=0 at trigger -> no latch pulse for that period. Drop enable mid-frame -> the frame completes, strobe fires, no frame at the next trigger.
6. Default parameters, pattern Start only (0x10) -> nes_latch high 152 cycles; strobe 2434 cycles after trigger; buttons=0x10; frame period 419583 cycles.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong design.
// Holds the NES button bit positions, the controller reader state
// encoding, and the default controller timing that other timing users
// also refer to.
package pong_pkg;

  // Bit positions within the active-high button byte
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  // 6 us per latch/clock phase and ~60 Hz polling at 25.175 MHz
  localparam int NES_PULSE_CYCLES = 152;
  localparam int NES_POLL_CYCLES  = 419583;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    DONE
  } nes_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous inputs.
// Ports:
//   clk   - destination clock
//   reset - synchronous active-high reset, loads RESET_VAL into both flops
//   d     - asynchronous input
//   q     - synchronized output, two clk cycles of latency
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Both stages reset to the same idle level so no false edge appears
  // on the output when reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_controller_reader.sv
// Serial reader for one NES controller.
// Generates the latch and shift-clock waveforms, shifts in the eight
// active-low button bits and presents them as an active-high byte plus
// a one-cycle mask of buttons newly pressed in the frame just read.
// Ports:
//   clk           - system clock
//   reset         - synchronous active-high reset, aborts a frame in progress
//   enable        - allows new frames to start; a running frame always completes
//   nes_data      - controller serial data, active-low, asynchronous
//   nes_latch     - controller latch strobe
//   nes_clk       - controller shift clock
//   buttons       - current button state, bit7 A ... bit0 Right
//   pressed       - buttons that went 0->1 this frame, only on the strobe cycle
//   buttons_valid - one-cycle strobe when buttons/pressed update
//   busy          - high whenever a frame is in progress
module nes_controller_reader
  import pong_pkg::*;
#(
  parameter int PULSE_CYCLES = NES_PULSE_CYCLES,
  parameter int POLL_CYCLES  = NES_POLL_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons,
  output logic [7:0] pressed,
  output logic       buttons_valid,
  output logic       busy
);

  localparam int PW  = ($clog2(PULSE_CYCLES) < 1) ? 1 : $clog2(PULSE_CYCLES);
  localparam int PLW = ($clog2(POLL_CYCLES) < 1) ? 1 : $clog2(POLL_CYCLES);
  localparam logic [PW-1:0]  PHASE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [PLW-1:0] POLL_LAST  = PLW'(POLL_CYCLES - 1);

  nes_state_t       state;
  nes_state_t       next_state;
  logic [PLW-1:0]   poll_cnt;
  logic [PW-1:0]    phase_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic [7:0]       prev_buttons;
  logic             data_sync;
  logic             phase_last;
  logic             poll_last;
  logic             trigger;

  // Idle level of the line is high (released), matching a pulled-up
  // input with no controller attached.
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_data_sync (
    .clk  (clk),
    .reset(reset),
    .d    (nes_data),
    .q    (data_sync)
  );

  assign phase_last = (phase_cnt == PHASE_LAST);
  assign poll_last  = (poll_cnt == POLL_LAST);
  assign trigger    = poll_last && enable;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; each timed phase ends on the last phase count
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (trigger)    next_state = LATCH;
      LATCH: if (phase_last) next_state = LOW;
      LOW:   if (phase_last) next_state = (bit_idx == 3'd7) ? DONE : HIGH;
      HIGH:  if (phase_last) next_state = LOW;
      DONE:                  next_state = IDLE;
      default:               next_state = IDLE;
    endcase
  end

  // Counters, bit capture and output registers. Controller pins and
  // busy are driven from next_state so they line up with the state
  // register and come straight out of flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      poll_cnt      <= '0;
      phase_cnt     <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      prev_buttons  <= '0;
      buttons       <= '0;
      pressed       <= '0;
      buttons_valid <= 1'b0;
      nes_latch     <= 1'b0;
      nes_clk       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      poll_cnt <= poll_last ? '0 : poll_cnt + 1'b1;

      if ((next_state != state) || (state == IDLE)) begin
        phase_cnt <= '0;
      end else begin
        phase_cnt <= phase_cnt + 1'b1;
      end

      if (state == LATCH) begin
        bit_idx <= '0;
      end else if ((state == HIGH) && phase_last) begin
        bit_idx <= bit_idx + 1'b1;
      end

      // Sample just before the rising shift clock, when the controller
      // output has been stable for the whole low phase.
      if ((state == LOW) && phase_last) begin
        shift_reg[3'd7 - bit_idx] <= ~data_sync;
      end

      if (state == DONE) begin
        buttons       <= shift_reg;
        pressed       <= shift_reg & ~prev_buttons;
        prev_buttons  <= shift_reg;
        buttons_valid <= 1'b1;
      end else begin
        pressed       <= '0;
        buttons_valid <= 1'b0;
      end

      nes_latch <= (next_state == LATCH);
      nes_clk   <= (next_state == HIGH);
      busy      <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_nes_controller_reader.sv
// Directed bench for nes_controller_reader with a behavioural NES pad.
// The main instance uses short timing (4-cycle phases, 100-cycle poll);
// a second instance uses the default phase length with a shortened poll
// period so two full frames fit in a short run.
module tb_nes_controller_reader;
  import pong_pkg::*;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_clk;
  logic [7:0] buttons;
  logic [7:0] pressed;
  logic       buttons_valid;
  logic       busy;

  logic       reset2;
  logic       enable2;
  logic       nes_data2;
  logic       nes_latch2;
  logic       nes_clk2;
  logic [7:0] buttons2;
  logic [7:0] pressed2;
  logic       buttons_valid2;
  logic       busy2;

  logic [7:0] pad_pattern;
  logic [7:0] pad_sh;
  logic       pad_unplugged;
  logic [7:0] pad_pattern2;
  logic [7:0] pad_sh2;

  int tests_run;
  int tests_failed;
  int cyc, lhi, cpul, chi, lst;

  nes_controller_reader #(
    .PULSE_CYCLES(4),
    .POLL_CYCLES (100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .nes_data     (nes_data),
    .nes_latch    (nes_latch),
    .nes_clk      (nes_clk),
    .buttons      (buttons),
    .pressed      (pressed),
    .buttons_valid(buttons_valid),
    .busy         (busy)
  );

  nes_controller_reader #(
    .PULSE_CYCLES(NES_PULSE_CYCLES),
    .POLL_CYCLES (3000)
  ) dut2 (
    .clk          (clk),
    .reset        (reset2),
    .enable       (enable2),
    .nes_data     (nes_data2),
    .nes_latch    (nes_latch2),
    .nes_clk      (nes_clk2),
    .buttons      (buttons2),
    .pressed      (pressed2),
    .buttons_valid(buttons_valid2),
    .busy         (busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pad model: latch loads the pattern (A first), each rising shift
  // clock moves the next button onto the data line; output is active-low.
  always @(posedge nes_latch or posedge nes_clk) begin
    if (nes_latch) pad_sh <= pad_pattern;
    else           pad_sh <= {pad_sh[6:0], 1'b0};
  end
  assign nes_data = pad_unplugged ? 1'b1 : ~pad_sh[7];

  always @(posedge nes_latch2 or posedge nes_clk2) begin
    if (nes_latch2) pad_sh2 <= pad_pattern2;
    else            pad_sh2 <= {pad_sh2[6:0], 1'b0};
  end
  assign nes_data2 = ~pad_sh2[7];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] pattern, input logic en, input logic unplugged);
    pad_pattern   = pattern;
    enable        = en;
    pad_unplugged = unplugged;
  endtask

  // Steps negedge by negedge until the strobe or the budget runs out,
  // measuring latch and shift-clock activity on the way.
  task automatic waitStrobe(input bit second, input int budget,
                            output int cycles, output int latch_hi,
                            output int clk_pulses, output int clk_hi,
                            output int latch_start);
    logic prev_c, v, l, c;
    bit seen;
    cycles = 0; latch_hi = 0; clk_pulses = 0; clk_hi = 0; latch_start = 0;
    prev_c = 1'b0; seen = 1'b0;
    while (!seen && (cycles < budget)) begin
      @(negedge clk);
      cycles++;
      v = second ? buttons_valid2 : buttons_valid;
      l = second ? nes_latch2 : nes_latch;
      c = second ? nes_clk2 : nes_clk;
      if (l) begin
        if (latch_hi == 0) latch_start = cycles;
        latch_hi++;
      end
      if (c && !prev_c) clk_pulses++;
      if (c) clk_hi++;
      prev_c = c;
      seen = v;
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    reset2 = 1'b1;
    enable2 = 1'b0;
    pad_pattern2 = 8'h10;
    applyStimulus(8'h5A, 1'b1, 1'b0);
    repeat (3) @(negedge clk);

    checkOutput("rst_latch", int'(nes_latch), 0);
    checkOutput("rst_clk", int'(nes_clk), 0);
    checkOutput("rst_buttons", int'(buttons), 0);
    checkOutput("rst_pressed", int'(pressed), 0);
    checkOutput("rst_valid", int'(buttons_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst2_latch", int'(nes_latch2), 0);

    // Frame 1: 0x5A
    reset = 1'b0;
    waitStrobe(1'b0, 400, cyc, lhi, cpul, chi, lst);
    checkOutput("f1_strobe_cycle", cyc, 165);
    checkOutput("f1_latch_start", lst, 100);
    checkOutput("f1_latch_len", lhi, 4);
    checkOutput("f1_clk_pulses", cpul, 7);
    checkOutput("f1_clk_high", chi, 28);
    checkOutput("f1_buttons", int'(buttons), 'h5A);
    checkOutput("f1_pressed", int'(pressed), 'h5A);
    @(negedge clk);
    checkOutput("f1_valid_drop", int'(buttons_valid), 0);
    checkOutput("f1_pressed_drop", int'(pressed), 0);
    checkOutput("f1_buttons_hold", int'(buttons), 'h5A);
    checkOutput("f1_idle", int'(busy), 0);

    // Frames 2 and 3: 0x5B, only Right newly pressed, then nothing new
    applyStimulus(8'h5B, 1'b1, 1'b0);
    waitStrobe(1'b0, 200, cyc, lhi, cpul, chi, lst);
    checkOutput("f2_period", cyc, 99);
    checkOutput("f2_buttons", int'(buttons), 'h5B);
    checkOutput("f2_pressed", int'(pressed), 'h01);
    @(negedge clk);
    waitStrobe(1'b0, 200, cyc, lhi, cpul, chi, lst);
    checkOutput("f3_strobe", cyc, 99);
    checkOutput("f3_valid", int'(buttons_valid), 1);
    checkOutput("f3_buttons", int'(buttons), 'h5B);
    checkOutput("f3_pressed", int'(pressed), 0);
    @(negedge clk);

    // No controller: line stays high, everything reads released
    applyStimulus(8'h5B, 1'b1, 1'b1);
    waitStrobe(1'b0, 200, cyc, lhi, cpul, chi, lst);
    checkOutput("nc1_strobe", cyc, 99);
    checkOutput("nc1_buttons", int'(buttons), 0);
    checkOutput("nc1_pressed", int'(pressed), 0);
    @(negedge clk);
    waitStrobe(1'b0, 200, cyc, lhi, cpul, chi, lst);
    checkOutput("nc2_strobe", cyc, 99);
    checkOutput("nc2_buttons", int'(buttons), 0);
    checkOutput("nc2_pressed", int'(pressed), 0);
    @(negedge clk);

    // Reset during the high phase of bit 3 (latch starts 34 cycles
    // ahead of here, bit 3 high runs 32..35 cycles after latch start)
    applyStimulus(8'hFF, 1'b1, 1'b0);
    repeat (67) @(negedge clk);
    checkOutput("b3_in_high", int'(nes_clk), 1);
    checkOutput("b3_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_latch", int'(nes_latch), 0);
    checkOutput("abort_clk", int'(nes_clk), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_buttons", int'(buttons), 0);
    checkOutput("abort_valid", int'(buttons_valid), 0);
    reset = 1'b0;
    waitStrobe(1'b0, 400, cyc, lhi, cpul, chi, lst);
    checkOutput("post_rst_latch_start", lst, 100);
    checkOutput("post_rst_strobe", cyc, 165);
    checkOutput("post_rst_buttons", int'(buttons), 'hFF);
    checkOutput("post_rst_pressed", int'(pressed), 'hFF);

    // Enable low across a trigger: no frame and no catch-up later
    applyStimulus(8'h81, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    waitStrobe(1'b0, 150, cyc, lhi, cpul, chi, lst);
    checkOutput("dis_no_strobe", cyc, 150);
    checkOutput("dis_no_latch", lhi, 0);
    enable = 1'b1;
    repeat (49) @(negedge clk);
    checkOutput("dis_no_catchup_busy", int'(busy), 0);
    checkOutput("dis_no_catchup_latch", int'(nes_latch), 0);
    @(negedge clk);
    checkOutput("en_latch_on_trigger", int'(nes_latch), 1);

    // Drop enable one cycle into the frame: it still completes
    enable = 1'b0;
    waitStrobe(1'b0, 200, cyc, lhi, cpul, chi, lst);
    checkOutput("drop_strobe", cyc, 65);
    checkOutput("drop_buttons", int'(buttons), 'h81);
    checkOutput("drop_pressed", int'(pressed), 'h81);
    waitStrobe(1'b0, 150, cyc, lhi, cpul, chi, lst);
    checkOutput("drop_no_next_frame", lhi, 0);
    checkOutput("drop_no_next_strobe", cyc, 150);

    // Default phase length, Start only; poll period shortened to 3000
    enable2 = 1'b1;
    reset2 = 1'b0;
    waitStrobe(1'b1, 6000, cyc, lhi, cpul, chi, lst);
    checkOutput("def_latch_start", lst, 3000);
    checkOutput("def_latch_len", lhi, 152);
    checkOutput("def_strobe", cyc, 2999 + 2434);
    checkOutput("def_clk_pulses", cpul, 7);
    checkOutput("def_clk_high", chi, 7 * 152);
    checkOutput("def_buttons", int'(buttons2), 'h10);
    checkOutput("def_pressed", int'(pressed2), 'h10);
    @(negedge clk);
    waitStrobe(1'b1, 3100, cyc, lhi, cpul, chi, lst);
    checkOutput("def_period", cyc, 2999);
    checkOutput("def_buttons2", int'(buttons2), 'h10);
    checkOutput("def_pressed2", int'(pressed2), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
